// File: rtl/i2s_seq_pkg.sv
// rtl/i2s_seq_pkg.sv - shared types and constants for the I2S APB sequencer
// FSM state encoding, status bit positions and default register map.
package i2s_seq_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CFG_S,
    CFG_A,
    POLL_S,
    POLL_A,
    TX_S,
    TX_A,
    RX_S,
    RX_A,
    STP_S,
    STP_A
  } seq_state_t;

  localparam int STAT_TXE  = 12;
  localparam int STAT_RXNE = 11;

  localparam logic [31:0] DEF_CTRL_ADR = 32'h0000_0000;
  localparam logic [31:0] DEF_TX_ADR   = 32'h0000_0004;
  localparam logic [31:0] DEF_RX_ADR   = 32'h0000_0008;
  localparam logic [31:0] DEF_STAT_ADR = 32'h0000_000C;
  localparam int          DEF_WDOG_LIM = 1024;

endpackage

// File: rtl/i2s_seq_arb.sv
// rtl/i2s_seq_arb.sv - 2-way round-robin between Tx and Rx service requests
// When both sides are pending, the side served last loses; Tx wins after reset or clr.
module i2s_seq_arb (
  input  logic pclk,
  input  logic preset,
  input  logic clr,
  input  logic tx_pend,
  input  logic rx_pend,
  input  logic grant_ack,
  output logic gnt_tx,
  output logic gnt_rx
);

  logic r_last_tx;

  assign gnt_tx = tx_pend & (~rx_pend | ~r_last_tx);
  assign gnt_rx = rx_pend & ~gnt_tx;

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      r_last_tx <= 1'b0;
    end else if (clr) begin
      r_last_tx <= 1'b0;
    end else if (grant_ack) begin
      r_last_tx <= gnt_tx;
    end
  end

endmodule

// File: rtl/i2s_apb_sequencer.sv
// rtl/i2s_apb_sequencer.sv - APB master sequencing the I2S transceiver registers
// Optional no-progress watchdog compiled in with I2S_SEQ_WDOG_EN.
module i2s_apb_sequencer
  import i2s_seq_pkg::*;
#(
  parameter logic [31:0] CTRL_ADR = DEF_CTRL_ADR,
  parameter logic [31:0] TX_ADR   = DEF_TX_ADR,
  parameter logic [31:0] RX_ADR   = DEF_RX_ADR,
  parameter logic [31:0] STAT_ADR = DEF_STAT_ADR
`ifdef I2S_SEQ_WDOG_EN
  ,
  parameter int          WDOG_LIM = DEF_WDOG_LIM
`endif
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        start,
  input  logic        stop,
  input  logic [14:0] cfg_word,
  input  logic [31:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  output logic        pwrite,
  output logic        penable,
  input  logic [31:0] prdata,
  output logic        busy,
  output logic        err
);

  seq_state_t r_state;
  logic       r_stop_req;
  logic       w_start;
  logic       w_poll_a;
  logic       w_gnt_tx;
  logic       w_gnt_rx;
  logic       w_wdog_hit;
  logic       w_go_stop;

  assign w_start  = (r_state == IDLE) & start;
  assign w_poll_a = (r_state == POLL_A);

  i2s_seq_arb u_arb (
    .pclk      (pclk),
    .preset    (preset),
    .clr       (w_start),
    .tx_pend   (prdata[STAT_TXE] & tx_valid),
    .rx_pend   (prdata[STAT_RXNE] & ~rx_valid),
    .grant_ack (w_poll_a & ~r_stop_req & (w_gnt_tx | w_gnt_rx)),
    .gnt_tx    (w_gnt_tx),
    .gnt_rx    (w_gnt_rx)
  );

`ifdef I2S_SEQ_WDOG_EN
  logic [10:0] r_wdog_cnt;
  logic        r_err;

  assign w_wdog_hit = (r_wdog_cnt == 11'(WDOG_LIM - 1));
  assign err        = r_err;

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      r_wdog_cnt <= '0;
      r_err      <= 1'b0;
    end else if (w_start) begin
      r_wdog_cnt <= '0;
      r_err      <= 1'b0;
    end else if (w_poll_a && !r_stop_req) begin
      if (w_gnt_tx || w_gnt_rx) begin
        r_wdog_cnt <= '0;
      end else if (w_wdog_hit) begin
        r_wdog_cnt <= '0;
        r_err      <= 1'b1;
      end else begin
        r_wdog_cnt <= r_wdog_cnt + 11'd1;
      end
    end
  end
`else
  assign w_wdog_hit = 1'b0;
  assign err        = 1'b0;
`endif

  // The watchdog only fires on a poll that selected no transfer.
  assign w_go_stop = r_stop_req | (w_wdog_hit & ~w_gnt_tx & ~w_gnt_rx);

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      r_stop_req <= 1'b0;
    end else if (r_state == IDLE) begin
      r_stop_req <= start & stop;
    end else if (stop) begin
      r_stop_req <= 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      r_state  <= IDLE;
      paddr    <= '0;
      pwdata   <= '0;
      pwrite   <= 1'b0;
      penable  <= 1'b0;
      tx_ready <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      tx_ready <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_state <= CFG_S;
          busy    <= 1'b1;
          paddr   <= CTRL_ADR;
          pwrite  <= 1'b1;
          pwdata  <= {17'b0, cfg_word};
        end
        CFG_S, POLL_S, RX_S, STP_S: begin
          r_state <= seq_state_t'(r_state + 4'd1);
          penable <= 1'b1;
        end
        TX_S: begin
          r_state  <= TX_A;
          penable  <= 1'b1;
          tx_ready <= 1'b1;
        end
        CFG_A, TX_A, RX_A: begin
          r_state <= POLL_S;
          penable <= 1'b0;
          paddr   <= STAT_ADR;
          pwrite  <= 1'b0;
          pwdata  <= '0;
          if (r_state == RX_A) begin
            rx_data  <= prdata;
            rx_valid <= 1'b1;
          end
        end
        POLL_A: begin
          penable <= 1'b0;
          if (w_go_stop) begin
            r_state <= STP_S;
            paddr   <= CTRL_ADR;
            pwrite  <= 1'b1;
            pwdata  <= '0;
          end else if (w_gnt_tx) begin
            r_state <= TX_S;
            paddr   <= TX_ADR;
            pwrite  <= 1'b1;
            pwdata  <= tx_data;
          end else if (w_gnt_rx) begin
            r_state <= RX_S;
            paddr   <= RX_ADR;
          end else begin
            r_state <= POLL_S;
          end
        end
        STP_A: begin
          r_state <= IDLE;
          penable <= 1'b0;
          busy    <= 1'b0;
          paddr   <= '0;
          pwrite  <= 1'b0;
          pwdata  <= '0;
        end
        default: begin
          r_state <= IDLE;
          penable <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
